// File: rtl/spi_reg_peripheral.sv
// SPI target with an 8-bit register file, selectable CPOL/CPHA and a registered debug readback port.
// Optional status readback on command bit6 is enabled by defining SPI_REG_STATUS_EN.
module spi_reg_peripheral #(
   parameter int ADDR_W      = 3,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic [ADDR_W-1:0] addr_in,
   output logic [7:0]        byte_out,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr
);
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;
   localparam logic        IDLE_SCK = (CPOL != 0);

   typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, primed;
   logic                   sck_s, cs_s, mosi_s, sck_prev, primed_done;
   logic                   sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync  <= {SYNC_STAGES{IDLE_SCK}};
         cs_sync   <= '1;
         mosi_sync <= '0;
         primed    <= '0;
         sck_prev  <= IDLE_SCK;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
         sck_prev  <= sck_s;
      end
   end

   assign sck_s       = sck_sync[SYNC_STAGES-1];
   assign cs_s        = cs_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign primed_done = primed[SYNC_STAGES-1];

   assign sck_edge    = sck_s ^ sck_prev;
   assign lead_edge   = sck_edge & (sck_s != IDLE_SCK);
   assign trail_edge  = sck_edge & (sck_s == IDLE_SCK);
   assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
   assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

   state_t            state;
   logic [7:0]        regs [NUM_REGS];
   logic [6:0]        rx_shift, tx_shift;
   logic [7:0]        rx_byte, wr_data, load_byte;
   logic [2:0]        bit_cnt;
   logic [ADDR_W-1:0] addr;
   logic              armed, wr_pend, load_next, miso_q;

   assign rx_byte = {rx_shift, mosi_s};

`ifdef SPI_REG_STATUS_EN
   logic [3:0] trans_cnt, write_cnt;
   logic       status_rd;
   assign load_byte = status_rd ? {trans_cnt, write_cnt} : regs[addr];
`else
   assign load_byte = regs[addr];
`endif

   // armed is set only by a genuinely high cs_n once the synchroniser holds real
   // samples, so a frame already in progress at reset release is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         wr_data   <= '0;
         bit_cnt   <= '0;
         addr      <= '0;
         armed     <= 1'b0;
         wr_pend   <= 1'b0;
         load_next <= 1'b0;
         miso_q    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         byte_out  <= '0;
`ifdef SPI_REG_STATUS_EN
         trans_cnt <= '0;
         write_cnt <= '0;
         status_rd <= 1'b0;
`endif
      end else begin
         wr_strobe <= 1'b0;
         byte_out  <= regs[addr_in];
         if (wr_pend) begin
            regs[addr] <= wr_data;
            wr_strobe  <= 1'b1;
            wr_addr    <= addr;
            addr       <= addr + 1'b1;
            wr_pend    <= 1'b0;
`ifdef SPI_REG_STATUS_EN
            write_cnt  <= write_cnt + 4'd1;
`endif
         end
         if (state != IDLE && cs_s) begin
            state  <= IDLE;
            miso_q <= 1'b0;
            armed  <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  miso_q <= 1'b0;
                  if (primed_done) begin
                     if (cs_s) begin
                        armed <= 1'b1;
                     end else if (armed) begin
                        state   <= CMD;
                        armed   <= 1'b0;
                        bit_cnt <= '0;
`ifdef SPI_REG_STATUS_EN
                        trans_cnt <= trans_cnt + 4'd1;
`endif
                     end
                  end
               end
               CMD: if (sample_edge) begin
                  rx_shift <= rx_byte[6:0];
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     addr      <= rx_byte[ADDR_W-1:0];
                     load_next <= 1'b1;
                     state     <= rx_byte[7] ? WR : RD;
`ifdef SPI_REG_STATUS_EN
                     status_rd <= ~rx_byte[7] & rx_byte[6];
`endif
                  end
               end
               WR: if (sample_edge) begin
                  rx_shift <= rx_byte[6:0];
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     wr_data <= rx_byte;
                     wr_pend <= 1'b1;
                  end
               end
               RD: begin
                  if (sample_edge) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) load_next <= 1'b1;
                  end
                  if (shift_edge) begin
                     if (load_next) begin
                        tx_shift  <= load_byte[6:0];
                        miso_q    <= load_byte[7];
                        load_next <= 1'b0;
`ifdef SPI_REG_STATUS_EN
                        if (!status_rd) addr <= addr + 1'b1;
`else
                        addr <= addr + 1'b1;
`endif
                     end else begin
                        tx_shift <= {tx_shift[5:0], 1'b0};
                        miso_q   <= tx_shift[6];
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = (state != IDLE) & ~cs_s;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: four instances, one per CPOL/CPHA mode, sharing clk/rst.
`timescale 1ns/1ps
module tb_spi_reg_peripheral;
   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sck, cs_n, miso, oe, wr_strobe;
   logic       mosi;
   logic [2:0] addr_in;
   logic [7:0] byte_out [4];
   logic [2:0] wr_addr [4];

   int         vectors = 0;
   int         miscompares = 0;
   int         strobe_cnt [4] = '{default: 0};
   logic [2:0] last_wr_addr [4] = '{default: '0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_reg_peripheral #(.ADDR_W(3), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) dut (
         .clk(clk), .rst(rst), .spi_sck(sck[g]), .spi_cs_n(cs_n[g]), .spi_mosi(mosi),
         .spi_miso(miso[g]), .spi_miso_oe(oe[g]), .addr_in(addr_in), .byte_out(byte_out[g]),
         .wr_strobe(wr_strobe[g]), .wr_addr(wr_addr[g])
      );
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_strobe[i] === 1'b1) begin
            strobe_cnt[i]   = strobe_cnt[i] + 1;
            last_wr_addr[i] = wr_addr[i];
         end
      end
   end

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start(input int m);
      cs_n[m] = 1'b0;
      idle_clks(HALF);
   endtask

   task automatic stop(input int m);
      cs_n[m] = 1'b1;
      idle_clks(2 * HALF);
   endtask

   task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      logic cpol, cpha;
      cpol = m[1];
      cpha = m[0];
      rx = '0;
      for (int b = 7; b > 7 - nbits; b--) begin
         if (cpha) sck[m] = ~cpol;
         mosi = tx[b];
         idle_clks(HALF);
         rx[b] = miso[m];
         sck[m] = cpha ? cpol : ~cpol;
         idle_clks(HALF);
         if (!cpha) sck[m] = cpol;
      end
      idle_clks(HALF);
   endtask

   task automatic peek(input logic [2:0] a);
      addr_in = a;
      idle_clks(2);
   endtask

   task automatic test_reset;
      rst = 1'b1; sck = 4'b1100; cs_n = '1; mosi = 1'b0; addr_in = '0;
      idle_clks(3);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({miso[i], oe[i], wr_strobe[i], wr_addr[i], byte_out[i]} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs m%0d: got miso=%b oe=%b stb=%b wa=%0d bo=%h want all 0",
                     i, miso[i], oe[i], wr_strobe[i], wr_addr[i], byte_out[i]);
         end
      end
      rst = 1'b0;
      idle_clks(4);
      for (int a = 0; a < 8; a++) begin
         peek(3'(a));
         vectors++;
         if (byte_out[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_reg%0d: got %h want 00", a, byte_out[0]);
         end
      end
   endtask

   task automatic test_single_write;
      logic [7:0] rx;
      int s0;
      s0 = strobe_cnt[0];
      start(0);
      vectors++;
      if (oe[0] !== 1'b1) begin miscompares++; $display("FAIL wr_oe: got %b want 1", oe[0]); end
      xfer(0, 8'h82, 8, rx);
      vectors++;
      if (rx !== 8'h00) begin miscompares++; $display("FAIL wr_cmd_miso: got %h want 00", rx); end
      xfer(0, 8'hA5, 8, rx);
      vectors++;
      if (rx !== 8'h00) begin miscompares++; $display("FAIL wr_data_miso: got %h want 00", rx); end
      stop(0);
      vectors++;
      if (strobe_cnt[0] - s0 !== 1 || last_wr_addr[0] !== 3'd2) begin
         miscompares++;
         $display("FAIL wr_strobe: got %0d strobes addr %0d want 1 addr 2", strobe_cnt[0] - s0, last_wr_addr[0]);
      end
      peek(3'd0);
      addr_in = 3'd2;
      @(negedge clk);
      vectors++;
      if (byte_out[0] !== 8'hA5) begin miscompares++; $display("FAIL dbg_latency: got %h want a5", byte_out[0]); end
   endtask

   task automatic test_burst_write;
      logic [7:0] rx;
      int s0;
      s0 = strobe_cnt[0];
      start(0);
      xfer(0, 8'h86, 8, rx);
      xfer(0, 8'h11, 8, rx);
      xfer(0, 8'h22, 8, rx);
      xfer(0, 8'h33, 8, rx);
      stop(0);
      vectors++;
      if (strobe_cnt[0] - s0 !== 3 || last_wr_addr[0] !== 3'd0) begin
         miscompares++;
         $display("FAIL burst_strobes: got %0d last addr %0d want 3 addr 0", strobe_cnt[0] - s0, last_wr_addr[0]);
      end
      peek(3'd6); vectors++;
      if (byte_out[0] !== 8'h11) begin miscompares++; $display("FAIL burst_reg6: got %h want 11", byte_out[0]); end
      peek(3'd7); vectors++;
      if (byte_out[0] !== 8'h22) begin miscompares++; $display("FAIL burst_reg7: got %h want 22", byte_out[0]); end
      peek(3'd0); vectors++;
      if (byte_out[0] !== 8'h33) begin miscompares++; $display("FAIL burst_wrap_reg0: got %h want 33", byte_out[0]); end
      peek(3'd2); vectors++;
      if (byte_out[0] !== 8'hA5) begin miscompares++; $display("FAIL burst_reg2_kept: got %h want a5", byte_out[0]); end
   endtask

   task automatic test_read_modes;
      logic [7:0] rx;
      int s0;
      for (int m = 0; m < 4; m++) begin
         s0 = strobe_cnt[m];
         start(m);
         xfer(m, 8'h80, 8, rx);
         xfer(m, 8'h3C, 8, rx);
         xfer(m, 8'hC3, 8, rx);
         stop(m);
         vectors++;
         if (strobe_cnt[m] - s0 !== 2) begin
            miscompares++; $display("FAIL rd_preload m%0d: got %0d strobes want 2", m, strobe_cnt[m] - s0);
         end
         start(m);
         vectors++;
         if (oe[m] !== 1'b1) begin miscompares++; $display("FAIL rd_oe_on m%0d: got %b want 1", m, oe[m]); end
         xfer(m, 8'h00, 8, rx);
         xfer(m, 8'hFF, 8, rx);
         vectors++;
         if (rx !== 8'h3C) begin miscompares++; $display("FAIL rd_byte0 m%0d: got %h want 3c", m, rx); end
         xfer(m, 8'hFF, 8, rx);
         vectors++;
         if (rx !== 8'hC3) begin miscompares++; $display("FAIL rd_byte1 m%0d: got %h want c3", m, rx); end
         stop(m);
         vectors++;
         if (oe[m] !== 1'b0) begin miscompares++; $display("FAIL rd_oe_off m%0d: got %b want 0", m, oe[m]); end
      end
   endtask

   task automatic test_abort;
      logic [7:0] rx;
      int s0;
      s0 = strobe_cnt[0];
      start(0);
      xfer(0, 8'h83, 8, rx);
      xfer(0, 8'hFF, 5, rx);
      stop(0);
      vectors++;
      if (strobe_cnt[0] !== s0) begin miscompares++; $display("FAIL abort_strobe: got %0d want 0", strobe_cnt[0] - s0); end
      peek(3'd3); vectors++;
      if (byte_out[0] !== 8'h00) begin miscompares++; $display("FAIL abort_reg3: got %h want 00", byte_out[0]); end
      start(0);
      xfer(0, 8'h83, 8, rx);
      xfer(0, 8'h5A, 8, rx);
      stop(0);
      vectors++;
      if (strobe_cnt[0] - s0 !== 1 || last_wr_addr[0] !== 3'd3) begin
         miscompares++;
         $display("FAIL abort_recover_strobe: got %0d addr %0d want 1 addr 3", strobe_cnt[0] - s0, last_wr_addr[0]);
      end
      peek(3'd3); vectors++;
      if (byte_out[0] !== 8'h5A) begin miscompares++; $display("FAIL abort_recover_reg3: got %h want 5a", byte_out[0]); end
      peek(3'd4); vectors++;
      if (byte_out[0] !== 8'h00) begin miscompares++; $display("FAIL abort_reg4: got %h want 00", byte_out[0]); end
   endtask

   task automatic test_reset_mid_read;
      logic [7:0] rx;
      addr_in = 3'd3;
      start(0);
      xfer(0, 8'h00, 8, rx);
      xfer(0, 8'hFF, 4, rx);
      vectors++;
      if (rx[7:4] !== 4'h3 || miso[0] !== 1'b1) begin
         miscompares++; $display("FAIL mid_read_pre: got nib %h miso %b want 3 1", rx[7:4], miso[0]);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({miso[0], oe[0], byte_out[0]} !== 10'h0) begin
         miscompares++; $display("FAIL async_reset: got miso=%b oe=%b bo=%h want 0", miso[0], oe[0], byte_out[0]);
      end
      idle_clks(2);
      rst = 1'b0;
      idle_clks(2);
      xfer(0, 8'hFF, 4, rx);
      vectors++;
      if (rx !== 8'h00 || oe[0] !== 1'b0) begin
         miscompares++; $display("FAIL post_reset_quiet: got rx=%h oe=%b want 00 0", rx, oe[0]);
      end
      stop(0);
      start(0);
      vectors++;
      if (oe[0] !== 1'b1) begin miscompares++; $display("FAIL new_frame_oe: got %b want 1", oe[0]); end
      xfer(0, 8'h00, 8, rx);
      xfer(0, 8'hFF, 8, rx);
      vectors++;
      if (rx !== 8'h00) begin miscompares++; $display("FAIL post_reset_reg0: got %h want 00", rx); end
      stop(0);
      peek(3'd1); vectors++;
      if (byte_out[0] !== 8'h00) begin miscompares++; $display("FAIL post_reset_reg1: got %h want 00", byte_out[0]); end
   endtask

`ifdef SPI_REG_STATUS_EN
   task automatic test_status;
      logic [7:0] rx;
      rst = 1'b1;
      idle_clks(2);
      rst = 1'b0;
      idle_clks(4);
      start(0); xfer(0, 8'h80, 8, rx); xfer(0, 8'h01, 8, rx); stop(0);
      start(0); xfer(0, 8'h81, 8, rx); xfer(0, 8'h02, 8, rx); stop(0);
      start(0);
      xfer(0, 8'h40, 8, rx);
      xfer(0, 8'hFF, 8, rx);
      vectors++;
      if (rx !== 8'h32) begin miscompares++; $display("FAIL status_byte: got %h want 32", rx); end
      xfer(0, 8'hFF, 8, rx);
      vectors++;
      if (rx !== 8'h32) begin miscompares++; $display("FAIL status_repeat: got %h want 32", rx); end
      stop(0);
   endtask
`else
   task automatic test_bit6_ignored;
      logic [7:0] rx;
      start(0); xfer(0, 8'h81, 8, rx); xfer(0, 8'h77, 8, rx); stop(0);
      start(0);
      xfer(0, 8'h41, 8, rx);
      xfer(0, 8'hFF, 8, rx);
      vectors++;
      if (rx !== 8'h77) begin miscompares++; $display("FAIL bit6_ignored: got %h want 77", rx); end
      stop(0);
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_burst_write();
      test_read_modes();
      test_abort();
      test_reset_mid_read();
`ifdef SPI_REG_STATUS_EN
      test_status();
`else
      test_bit6_ignored();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
